// File: rtl/blockade_pkg.sv
// Shared types and default constants for the blockade clock/reset controller.
package blockade_pkg;

  typedef enum logic [1:0] {
    CLK_WAIT_LOCK = 2'd0,
    CLK_HOLD      = 2'd1,
    CLK_RUN       = 2'd2
  } clk_state_t;

  localparam int unsigned RESET_HOLD_DEF = 1024;
  localparam int unsigned CPU_DIV_DEF    = 10;
  localparam int unsigned PIX_DIV_DEF    = 4;

endpackage

// File: rtl/blockade_clk_ctrl_ce_divider.sv
// Single-cycle clock-enable generator: counts 0..DIV-1 on adv, pulses ce on the last count.
module ce_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_sys,
  input  logic clr,
  input  logic adv,
  output logic ce
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;
  logic         at_end;

  assign at_end = (cnt == W'(DIV - 1));

  // Counter freezes (phase preserved) whenever adv is low.
  always_ff @(posedge clk_sys) begin
    if (clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= at_end ? '0 : cnt + 1'b1;
    end
  end

  assign ce = at_end && adv && !clr;

endmodule

// File: rtl/blockade_clk_ctrl.sv
// PLL-lock driven core reset sequencer plus CPU/pixel clock-enable generation in clk_sys.
module blockade_clk_ctrl
  import blockade_pkg::*;
#(
  parameter int unsigned RESET_HOLD = RESET_HOLD_DEF,
  parameter int unsigned CPU_DIV    = CPU_DIV_DEF,
  parameter int unsigned PIX_DIV    = PIX_DIV_DEF
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pll_locked,
  input  logic pause,
  output logic core_reset,
  output logic ce_cpu,
  output logic ce_pix,
  output logic running
);

  localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  logic              lock_m, lock_s;
  clk_state_t        state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              div_clr;

  // Lock synchronizer deliberately ignores reset so lock status survives an OSD reset.
  always_ff @(posedge clk_sys) begin
    lock_m <= pll_locked;
    lock_s <= lock_m;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= CLK_WAIT_LOCK;
    else       state <= state_nxt;
  end

  assign hold_done = (hold_cnt == HOLD_W'(RESET_HOLD - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLK_WAIT_LOCK: if (lock_s) state_nxt = CLK_HOLD;
      CLK_HOLD: begin
        if (!lock_s)        state_nxt = CLK_WAIT_LOCK;
        else if (hold_done) state_nxt = CLK_RUN;
      end
      CLK_RUN:       if (!lock_s) state_nxt = CLK_WAIT_LOCK;
      default:       state_nxt = CLK_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset || state != CLK_HOLD) hold_cnt <= '0;
    else if (!hold_done)            hold_cnt <= hold_cnt + 1'b1;
  end

  always_comb begin
    core_reset = 1'b1;
    running    = 1'b0;
    div_clr    = 1'b1;
    if (state == CLK_RUN) begin
      core_reset = 1'b0;
      running    = 1'b1;
      div_clr    = 1'b0;
    end
  end

  ce_divider #(.DIV(PIX_DIV)) u_pix_div (
    .clk_sys (clk_sys),
    .clr     (div_clr),
    .adv     (1'b1),
    .ce      (ce_pix)
  );

  ce_divider #(.DIV(CPU_DIV)) u_cpu_div (
    .clk_sys (clk_sys),
    .clr     (div_clr),
    .adv     (!pause),
    .ce      (ce_cpu)
  );

endmodule

// File: tb/tb_blockade_clk_ctrl.sv
// Directed bench for blockade_clk_ctrl with RESET_HOLD=16, CPU_DIV=10, PIX_DIV=4.
module tb_blockade_clk_ctrl;

  logic clk_sys = 1'b0;
  logic reset, pll_locked, pause;
  logic core_reset, ce_cpu, ce_pix, running;

  int n_checks = 0;
  int n_pass   = 0;

  blockade_clk_ctrl #(
    .RESET_HOLD (16),
    .CPU_DIV    (10),
    .PIX_DIV    (4)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pll_locked (pll_locked),
    .pause      (pause),
    .core_reset (core_reset),
    .ce_cpu     (ce_cpu),
    .ce_pix     (ce_pix),
    .running    (running)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Ticks until core_reset falls; returns 2000 on timeout.
  task automatic wait_release(output int n);
    n = 0;
    while (core_reset && n < 2000) begin
      tick();
      n++;
    end
  endtask

  // Entered while sampling RUN cycle 1; records enables for RUN cycles 1..n,
  // with pause high during RUN cycles ps..pe.
  task automatic capture(input int n, input int ps, input int pe,
                         output logic [63:0] pm, output logic [63:0] cm);
    pm = '0;
    cm = '0;
    for (int k = 1; k <= n; k++) begin
      pause = (k >= ps && k <= pe);
      #1;
      pm[k-1] = ce_pix;
      cm[k-1] = ce_cpu;
      if (k < n) tick();
    end
    pause = 1'b0;
  endtask

  initial begin
    int          rel;
    logic [63:0] pm, cm, cpu_pause_exp;
    int          pix_cnt, cpu_cnt, wide;
    logic        prev_pix, prev_cpu;

    reset      = 1'b1;
    pll_locked = 1'b0;
    pause      = 1'b0;
    repeat (3) tick();
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_running",    64'(running),    64'd0);
    check("rst_ce_pix",     64'(ce_pix),     64'd0);
    check("rst_ce_cpu",     64'(ce_cpu),     64'd0);

    // Power-up: 2 sync + 1 enter HOLD + 16 hold cycles.
    reset      = 1'b0;
    pll_locked = 1'b1;
    wait_release(rel);
    check("powerup_release", 64'(rel), 64'd19);
    check("powerup_running", 64'(running), 64'd1);
    capture(20, 99, 0, pm, cm);
    check("powerup_pix_mask", pm, 64'h88888);
    check("powerup_cpu_mask", cm, 64'h80200);

    // Lock loss in RUN at RUN cycle 21; cycle 24 would otherwise be a ce_pix.
    tick();
    pll_locked = 1'b0;
    tick();
    tick();
    check("lockloss_pre", 64'(core_reset), 64'd0);
    tick();
    check("lockloss_core_reset", 64'(core_reset), 64'd1);
    check("lockloss_ce_pix",     64'(ce_pix),     64'd0);
    check("lockloss_running",    64'(running),    64'd0);
    repeat (5) tick();
    pll_locked = 1'b1;
    wait_release(rel);
    check("relock_release", 64'(rel), 64'd19);

    // Pause from CPU count 6 (RUN cycle 7) for 25 cycles.
    capture(60, 7, 31, pm, cm);
    cpu_pause_exp = (64'd1 << 34) | (64'd1 << 44) | (64'd1 << 54);
    check("pause_pix_mask", pm, 64'h0888888888888888);
    check("pause_cpu_mask", cm, cpu_pause_exp);

    // One-cycle reset pulse in RUN.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstpulse_core_reset", 64'(core_reset), 64'd1);
    check("rstpulse_ce_cpu",     64'(ce_cpu),     64'd0);
    wait_release(rel);
    check("rstpulse_release", 64'(rel), 64'd17);
    capture(20, 99, 0, pm, cm);
    check("rstpulse_pix_mask", pm, 64'h88888);
    check("rstpulse_cpu_mask", cm, 64'h80200);

    // Lock glitch mid-HOLD restarts the whole hold count.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    check("glitch_core_reset", 64'(core_reset), 64'd1);
    wait_release(rel);
    check("glitch_release", 64'(rel), 64'd19);

    // Long steady-state run.
    pix_cnt  = 0;
    cpu_cnt  = 0;
    wide     = 0;
    prev_pix = 1'b0;
    prev_cpu = 1'b0;
    for (int k = 1; k <= 10000; k++) begin
      if (ce_pix) pix_cnt++;
      if (ce_cpu) cpu_cnt++;
      if ((ce_pix && prev_pix) || (ce_cpu && prev_cpu)) wide++;
      prev_pix = ce_pix;
      prev_cpu = ce_cpu;
      if (k < 10000) tick();
    end
    check("long_pix_count", 64'(pix_cnt), 64'd2500);
    check("long_cpu_count", 64'(cpu_cnt), 64'd1000);
    check("long_wide",      64'(wide),    64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
